// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, per-stage default widths and ctrl bit indices for pipeline stages
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b01;
  localparam logic [1:0] ST_SKID  = 2'b10;

  localparam int IFID_CTRL_W  = 4;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 16;
  localparam int IDEX_DATA_W  = 160;
  localparam int EXMEM_CTRL_W = 16;
  localparam int EXMEM_DATA_W = 128;
  localparam int MEMWB_CTRL_W = 8;
  localparam int MEMWB_DATA_W = 96;

  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_CSR_WE    = 3;
  localparam int CTRL_BRANCH    = 4;
  localparam int CTRL_JUMP      = 5;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC   = 7;

  function automatic logic [1:0] occ_of(input logic [1:0] st);
    return st == ST_SKID ? 2'd2 : st == ST_FULL ? 2'd1 : 2'd0;
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter, cleared only by asynchronous active-low reset
module pipe_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // count events, holding at all-ones once reached
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && count != '1) count <= count + CNT_W'(1);

endmodule

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline register with 2-entry skid buffer; perf counters under PIPE_SKID_STAGE_PERF_EN
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [1:0]        state, state_nx;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              accept, drain, load_main, load_skid, from_skid;

  assign out_valid = state != ST_EMPTY;
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign occupancy = occ_of(state);

  // handshake decode and next state; flush overrides everything
  always_comb begin
    accept    = in_valid & in_ready;
    drain     = out_valid & out_ready;
    state_nx  = flush ? ST_EMPTY :
                state == ST_EMPTY ? (accept ? ST_FULL : ST_EMPTY) :
                state == ST_FULL  ? (accept & !drain ? ST_SKID : !accept & drain ? ST_EMPTY : ST_FULL) :
                state == ST_SKID  ? (drain ? ST_FULL : ST_SKID) : ST_EMPTY;
    load_main = !flush & accept & (state == ST_EMPTY | (state == ST_FULL & drain));
    load_skid = !flush & accept & state == ST_FULL & !drain;
    from_skid = !flush & state == ST_SKID & drain;
  end

  // state and registered in_ready: accept unless the next cycle holds two entries
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != ST_SKID;
    end

  // main slot takes fresh input or the promoted skid entry; held otherwise, including on flush
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      main_data <= '0;
      main_ctrl <= '0;
    end else if (load_main) begin
      main_data <= in_data;
      main_ctrl <= in_ctrl;
    end else if (from_skid) begin
      main_data <= skid_data;
      main_ctrl <= skid_ctrl;
    end

  // skid slot captures the input that arrives while the main slot is stalled
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (load_skid) begin
      skid_data <= in_data;
      skid_ctrl <= in_ctrl;
    end

`ifdef PIPE_SKID_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset_n(reset_n), .inc(out_valid & ~out_ready), .count(stall_cnt)
  );
  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk(clk), .reset_n(reset_n), .inc(~out_valid & out_ready), .count(bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
